// File: rtl/pipe_arbiter_if.sv
// Handshake and data bundle between two requesters, the shared multiply-add pipe
// and the round-robin pipe_arbiter that owns issue order and response routing.
interface pipe_arbiter_if;
   logic       req0_valid;
   logic       req1_valid;
   logic [2:0] req0_data1;
   logic [2:0] req0_data2;
   logic [2:0] req1_data1;
   logic [2:0] req1_data2;
   logic       req0_ready;
   logic       req1_ready;
   logic       pipe_in_valid;
   logic [2:0] pipe_in_data1;
   logic [2:0] pipe_in_data2;
   logic [7:0] pipe_out_data;
   logic       resp_valid;
   logic       resp_id;
   logic [7:0] resp_data;
   logic       busy;

   modport master (
      output req0_valid, req1_valid, req0_data1, req0_data2, req1_data1, req1_data2,
      output pipe_out_data,
      input  req0_ready, req1_ready, pipe_in_valid, pipe_in_data1, pipe_in_data2,
      input  resp_valid, resp_id, resp_data, busy
   );

   modport slave (
      input  req0_valid, req1_valid, req0_data1, req0_data2, req1_data1, req1_data2,
      input  pipe_out_data,
      output req0_ready, req1_ready, pipe_in_valid, pipe_in_data1, pipe_in_data2,
      output resp_valid, resp_id, resp_data, busy
   );
endinterface

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency multiply-add pipe between two
// requesters; keeps the pipe clocked with bubbles until in-flight results drain.
module pipe_arbiter #(
   parameter int PIPE_LAT     = 3,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   pipe_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t               state_r;
   logic                 ptr_r;
   logic [CNT_W-1:0]     flush_cnt_r;
   logic                 busy_r;
   logic [PIPE_LAT-1:0]  tag_v_r;
   logic [PIPE_LAT-1:0]  tag_id_r;
   logic                 resp_valid_r;
   logic                 resp_id_r;
   logic [7:0]           resp_data_r;

   logic                 grant0_s;
   logic                 grant1_s;
   logic                 any_grant_s;
   logic                 issue_s;
   logic [2:0]           op1_s;
   logic [2:0]           op2_s;

   // Grant selection; ptr_r names the requester that wins a tie.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (rst_n) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant0_s = ~ptr_r;
            grant1_s = ptr_r;
         end else begin
            grant0_s = bus.req0_valid;
            grant1_s = bus.req1_valid;
         end
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // Operand mux: a grant replaces the bubble that RUN/FLUSH would otherwise send.
   always_comb begin
      any_grant_s = grant0_s | grant1_s;
      issue_s     = rst_n & (any_grant_s | (state_r != IDLE));
      op1_s       = 3'd0;
      op2_s       = 3'd0;
      if (grant0_s) begin
         op1_s = bus.req0_data1;
         op2_s = bus.req0_data2;
      end else if (grant1_s) begin
         op1_s = bus.req1_data1;
         op2_s = bus.req1_data2;
      end else begin
         op1_s = 3'd0;
         op2_s = 3'd0;
      end
   end

   // Control FSM; the RUN cycle that sees no request is already the first bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         ptr_r       <= 1'b0;
         flush_cnt_r <= '0;
         busy_r      <= 1'b0;
      end else begin
         if (bus.req0_valid && bus.req1_valid) begin
            ptr_r <= ~ptr_r;
         end else begin
            ptr_r <= ptr_r;
         end
         case (state_r)
            IDLE: begin
               if (any_grant_s) begin
                  state_r <= RUN;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            RUN: begin
               if (any_grant_s) begin
                  state_r <= RUN;
                  busy_r  <= 1'b1;
               end else if (FLUSH_CYCLES > 1) begin
                  state_r     <= FLUSH;
                  flush_cnt_r <= CNT_W'(FLUSH_CYCLES - 1);
                  busy_r      <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            FLUSH: begin
               if (any_grant_s) begin
                  state_r     <= RUN;
                  flush_cnt_r <= '0;
                  busy_r      <= 1'b1;
               end else if (flush_cnt_r <= CNT_W'(1)) begin
                  state_r     <= IDLE;
                  flush_cnt_r <= '0;
                  busy_r      <= 1'b0;
               end else begin
                  state_r     <= FLUSH;
                  flush_cnt_r <= flush_cnt_r - CNT_W'(1);
                  busy_r      <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               flush_cnt_r <= '0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // Tag pipe mirrors the shared pipe; the oldest tag is retired exactly once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v_r      <= '0;
         tag_id_r     <= '0;
         resp_valid_r <= 1'b0;
         resp_id_r    <= 1'b0;
         resp_data_r  <= 8'd0;
      end else begin
         if (issue_s) begin
            tag_v_r  <= {tag_v_r[PIPE_LAT-2:0], any_grant_s};
            tag_id_r <= {tag_id_r[PIPE_LAT-2:0], grant1_s};
         end else begin
            tag_v_r  <= {1'b0, tag_v_r[PIPE_LAT-2:0]};
            tag_id_r <= tag_id_r;
         end
         resp_valid_r <= tag_v_r[PIPE_LAT-1];
         resp_id_r    <= tag_v_r[PIPE_LAT-1] & tag_id_r[PIPE_LAT-1];
         resp_data_r  <= tag_v_r[PIPE_LAT-1] ? bus.pipe_out_data : 8'd0;
      end
   end

   assign bus.req0_ready    = grant0_s;
   assign bus.req1_ready    = grant1_s;
   assign bus.pipe_in_valid = issue_s;
   assign bus.pipe_in_data1 = op1_s;
   assign bus.pipe_in_data2 = op2_s;
   assign bus.resp_valid    = resp_valid_r;
   assign bus.resp_id       = resp_id_r;
   assign bus.resp_data     = resp_data_r;
   assign bus.busy          = busy_r;
endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter: external 3-stage multiply-add pipe, a per-cycle
// transaction model of grants/drain/responses, and literal spot checks.
module tb_pipe_arbiter;
   localparam int PIPE_LAT     = 3;
   localparam int FLUSH_CYCLES = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   pipe_arbiter_if bus();

   pipe_arbiter #(.PIPE_LAT(PIPE_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Shared pipe: result of an issue at edge k is visible after edge k+2.
   logic [7:0] p0, p1, p2;
   always_ff @(posedge clk) begin
      p0 <= bus.pipe_in_valid ? (8'(bus.pipe_in_data1) * 8'(bus.pipe_in_data2) + 8'(bus.pipe_in_data2)) : 8'd0;
      p1 <= p0;
      p2 <= p1;
   end
   assign bus.pipe_out_data = p2;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int due;
      int id;
      int data;
   } exp_t;

   int   checks = 0;
   int   passes = 0;
   bit   m_ptr = 1'b0;
   int   last_g = -100;
   exp_t q[$];
   int   piv_cnt = 0;
   int   resp_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Transaction model: grants from valids + tie pointer, drain window, due responses.
   task automatic model_cmp();
      bit g0, g1, busy_e;
      int d1, d2;
      if (!rst_n) begin
         check("rst_ready0", bus.req0_ready, 0);
         check("rst_ready1", bus.req1_ready, 0);
         check("rst_piv", bus.pipe_in_valid, 0);
         check("rst_busy", bus.busy, 0);
         check("rst_resp_valid", bus.resp_valid, 0);
         check("rst_resp_data", bus.resp_data, 0);
         m_ptr  = 1'b0;
         last_g = -100;
         q.delete();
      end else begin
         if (bus.req0_valid && bus.req1_valid) begin
            g0 = !m_ptr;
            g1 = m_ptr;
            m_ptr = !m_ptr;
         end else begin
            g0 = bus.req0_valid;
            g1 = bus.req1_valid;
         end
         d1 = g0 ? int'(bus.req0_data1) : (g1 ? int'(bus.req1_data1) : 0);
         d2 = g0 ? int'(bus.req0_data2) : (g1 ? int'(bus.req1_data2) : 0);
         busy_e = (cyc - last_g) < FLUSH_CYCLES;
         check("ready0", bus.req0_ready, g0);
         check("ready1", bus.req1_ready, g1);
         check("busy", bus.busy, busy_e);
         check("pipe_in_valid", bus.pipe_in_valid, g0 || g1 || busy_e);
         check("pipe_in_data1", bus.pipe_in_data1, d1);
         check("pipe_in_data2", bus.pipe_in_data2, d2);
         if (q.size() > 0 && q[0].due == cyc) begin
            check("resp_valid", bus.resp_valid, 1);
            check("resp_id", bus.resp_id, q[0].id);
            check("resp_data", bus.resp_data, q[0].data);
            void'(q.pop_front());
         end else begin
            check("resp_valid", bus.resp_valid, 0);
            check("resp_id", bus.resp_id, 0);
            check("resp_data", bus.resp_data, 0);
         end
         if (g0 || g1) begin
            last_g = cyc + 1;
            q.push_back('{cyc + 1 + PIPE_LAT, int'(g1), d2 * d1 + d2});
         end
         if (bus.pipe_in_valid) piv_cnt++;
         if (bus.resp_valid) resp_cnt++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_cmp();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_req(input int id, input bit v, input int a, input int b);
      if (id == 0) begin
         bus.req0_valid = v;
         bus.req0_data1 = 3'(a);
         bus.req0_data2 = 3'(b);
      end else begin
         bus.req1_valid = v;
         bus.req1_data1 = 3'(a);
         bus.req1_data2 = 3'(b);
      end
   endtask

   initial begin
      int base_piv, base_resp;
      bit exp_alt[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      set_req(0, 1'b0, 0, 0);
      set_req(1, 1'b0, 0, 0);
      do_reset();
      tick();

      // Single request, then drain to IDLE.
      base_piv  = piv_cnt;
      base_resp = resp_cnt;
      set_req(0, 1'b1, 3, 5);
      #1;
      check("a_ready0", bus.req0_ready, 1);
      check("a_ready1", bus.req1_ready, 0);
      tick();
      bus.req0_valid = 1'b0;
      repeat (3) tick();
      check("a_resp_valid", bus.resp_valid, 1);
      check("a_resp_id", bus.resp_id, 0);
      check("a_resp_data", bus.resp_data, 20);
      tick();
      check("a_resp_pulse", bus.resp_valid, 0);
      repeat (2) tick();
      check("a_piv_cycles", piv_cnt - base_piv, 3);
      check("a_resp_count", resp_cnt - base_resp, 1);
      check("a_busy_idle", bus.busy, 0);

      // Contention from reset: req0 first, then req1.
      do_reset();
      set_req(0, 1'b1, 2, 1);
      set_req(1, 1'b1, 7, 7);
      #1;
      check("b_ready0", bus.req0_ready, 1);
      check("b_ready1_wait", bus.req1_ready, 0);
      tick();
      bus.req0_valid = 1'b0;
      #1;
      check("b_ready1", bus.req1_ready, 1);
      tick();
      bus.req1_valid = 1'b0;
      repeat (2) tick();
      check("b_resp0_id", bus.resp_id, 0);
      check("b_resp0_data", bus.resp_data, 3);
      tick();
      check("b_resp1_valid", bus.resp_valid, 1);
      check("b_resp1_id", bus.resp_id, 1);
      check("b_resp1_data", bus.resp_data, 56);
      repeat (3) tick();

      // Request arriving in the first FLUSH cycle replaces the bubble.
      do_reset();
      set_req(0, 1'b1, 1, 1);
      tick();
      bus.req0_valid = 1'b0;
      tick();
      set_req(1, 1'b1, 4, 2);
      #1;
      check("c_busy_flush", bus.busy, 1);
      check("c_ready1", bus.req1_ready, 1);
      check("c_pipe_data1", bus.pipe_in_data1, 4);
      tick();
      bus.req1_valid = 1'b0;
      check("c_busy_run", bus.busy, 1);
      tick();
      check("c_resp0_data", bus.resp_data, 2);
      tick();
      check("c_bubble_noresp", bus.resp_valid, 0);
      tick();
      check("c_resp1_valid", bus.resp_valid, 1);
      check("c_resp1_id", bus.resp_id, 1);
      check("c_resp1_data", bus.resp_data, 10);
      repeat (2) tick();

      // Six cycles of dual requests: strict alternation and six responses.
      do_reset();
      base_resp = resp_cnt;
      for (int i = 0; i < 6; i++) begin
         set_req(0, 1'b1, i, (i + 1) % 8);
         set_req(1, 1'b1, 7 - i, i);
         #1;
         check("d_alt_ready1", bus.req1_ready, exp_alt[i]);
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      repeat (6) tick();
      check("d_resp_count", resp_cnt - base_resp, 6);

      // Reset mid-stream discards everything in flight.
      set_req(0, 1'b1, 5, 6);
      set_req(1, 1'b1, 6, 5);
      repeat (2) tick();
      rst_n = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #1;
      check("e_rst_resp_valid", bus.resp_valid, 0);
      check("e_rst_busy", bus.busy, 0);
      check("e_rst_piv", bus.pipe_in_valid, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      base_resp = resp_cnt;
      repeat (6) tick();
      check("e_no_resp_after_rst", resp_cnt - base_resp, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/pipe_arbiter.md
PIPE_ARBITER -- requirements
Module: pipe_arbiter

Interface
REQ-001 Parameter: PIPE_LAT, 3, cycles from an accepted request sampled at edge k to its result registered on pipe_out_data (visible after edge k+PIPE_LAT-1).
REQ-002 Parameter: FLUSH_CYCLES, 2, extra cycles pipe_in_valid stays high after the last real issue so the shared pipe advances and drains.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req0_valid, req1_valid  input  1 each  requester operand pair valid.
REQ-006 Port: req0_data1, req0_data2, req1_data1, req1_data2  input  3 each  operands a and b.
REQ-007 Port: req0_ready, req1_ready  output  1 each  grant; transfer occurs when valid and ready are both high at a rising edge.
REQ-008 Port: pipe_in_valid  output  1  drives the shared multiply-add pipe in_valid.
REQ-009 Port: pipe_in_data1, pipe_in_data2  output  3 each  operands to the pipe.
REQ-010 Port: pipe_out_data  input  8  pipe result a*b+b; the pipe's out_valid is not used.
REQ-011 Port: resp_valid  output  1  one-cycle result pulse.
REQ-012 Port: resp_id  output  1  requester owning resp_data (0 or 1).
REQ-013 Port: resp_data  output  8  returned result.
REQ-014 Port: busy  output  1  high in RUN or FLUSH.

Function
REQ-015 The block SHALL implement states IDLE, RUN and FLUSH.
REQ-016 Ready SHALL be combinational from the req valids and the round-robin pointer; at most one ready high per cycle, and none without a matching valid.
REQ-017 Single requester valid: it SHALL be granted. Both valid: the pointer's requester SHALL be granted, and the pointer SHALL then point to the other requester.
REQ-018 On a grant, pipe_in_valid SHALL be 1 and pipe_in_data1/2 SHALL equal the granted operands in the same cycle.
REQ-019 IDLE: no valid keeps IDLE with pipe_in_valid=0 and operands 0; any valid grants and moves to RUN.
REQ-020 RUN: each cycle with a valid grants and stays in RUN; a cycle with no valid enters FLUSH and loads the flush counter with FLUSH_CYCLES.
REQ-021 FLUSH: each cycle SHALL drive pipe_in_valid=1 with operands 0 as a bubble and decrement the counter.
REQ-022 In FLUSH, a valid request SHALL be granted that cycle, replacing the bubble, and the state SHALL return to RUN.
REQ-023 FLUSH SHALL go to IDLE when the counter reaches 0.
REQ-024 A PIPE_LAT-deep tag shift register (valid bit + id) SHALL advance every cycle pipe_in_valid=1; bubbles insert an invalid tag.
REQ-025 When the tag at depth PIPE_LAT is valid, resp_valid=1, resp_id=tag id and resp_data=pipe_out_data SHALL be registered, so a request accepted at edge k responds in the cycle after edge k+PIPE_LAT.
REQ-026 No response SHALL occur for bubbles; otherwise resp_valid=0, resp_data=0 and resp_id=0.
REQ-027 Back-to-back grants SHALL sustain one result per cycle, in issue order.
REQ-028 There is no response backpressure; requesters SHALL accept resp_valid pulses unconditionally.
REQ-029 Arithmetic is owned by the pipe (max 7*7+7=56, fits 8 bits); the arbiter SHALL pass data unmodified.

Reset
REQ-030 rst_n low SHALL asynchronously clear the state to IDLE, the pointer to requester 0, the flush counter and all tags, and every output to 0.
REQ-031 Reset mid-operation SHALL discard all in-flight tags; no resp_valid SHALL be emitted for requests accepted before reset.

Verification
REQ-032 After reset, req0 (3,5) for one cycle at edge k: req0_ready=1 that cycle; resp_valid=1, resp_id=0 and resp_data=20 for one cycle after edge k+3.
REQ-033 req0 (2,1) and req1 (7,7) both valid: req0 granted first, then req1; responses are id0/3, then id1/56 on consecutive cycles.
REQ-034 Single accepted request then no valids: pipe_in_valid high for exactly 3 cycles (1 issue + 2 bubbles), busy falls, state IDLE, exactly one resp_valid.
REQ-035 req1 valid during the first FLUSH cycle: granted immediately, state RUN, its result returns 3 cycles after acceptance, and no response for the bubble.
REQ-036 Continuous dual requests for 6 cycles: strict alternation 0,1,0,1,0,1; six responses with matching ids; rst_n pulsed mid-stream gives no further resp_valid and all outputs 0.
